// File: rtl/ci_cos_initiator.sv
// Streams float32 angles to a multi-cycle CI cos slave, one request at a time,
// and returns each result (or a qNaN filler on timeout) on an output stream.
module ci_cos_initiator #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              ci_clk_en,
  output logic              ci_reset,
  output logic              ci_start,
  output logic [DATA_W-1:0] ci_dataa,
  input  logic              ci_done,
  input  logic [DATA_W-1:0] ci_result,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_timeout,
  input  logic              out_ready,
  output logic              busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]        state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wp;
  logic [AW:0]       rp;
  logic [CW-1:0]     cnt;
  logic              to_pulse;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);

  assign in_ready  = clk_en & ~full;
  assign push      = in_valid & in_ready;
  assign pop       = clk_en & (state == S_ISSUE);
  assign ci_clk_en = clk_en;
  assign ci_reset  = reset | to_pulse;
  assign ci_start  = (state == S_ISSUE);
  assign busy      = (state != S_IDLE) | ~empty;

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      wp          <= '0;
      rp          <= '0;
      cnt         <= '0;
      to_pulse    <= 1'b0;
      ci_dataa    <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_timeout <= 1'b0;
    end else if (clk_en) begin
      to_pulse <= 1'b0;
      if (push) wp <= wp + (AW+1)'(1);
      if (pop)  rp <= rp + (AW+1)'(1);
      unique case (state)
        S_IDLE: begin
          // dataa is loaded here so it is already stable while start is high
          if (!empty && !out_valid) begin
            state    <= S_ISSUE;
            ci_dataa <= mem[rp[AW-1:0]];
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
          cnt   <= '0;
        end
        S_WAIT: begin
          if (ci_done) begin
            state       <= S_HOLD;
            out_valid   <= 1'b1;
            out_data    <= ci_result;
            out_timeout <= 1'b0;
          end else if (cnt == CW'(TIMEOUT-1)) begin
            state       <= S_HOLD;
            out_valid   <= 1'b1;
            out_data    <= DATA_W'(32'h7fc00000);
            out_timeout <= 1'b1;
            to_pulse    <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ci_cos_initiator.sv
// Scoreboard bench for ci_cos_initiator with a behavioural CI cos slave.
// Directed sweeps cover latency, backpressure, timeout, freeze and reset.
module tb_ci_cos_initiator;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        ci_clk_en;
  logic        ci_reset;
  logic        ci_start;
  logic [31:0] ci_dataa;
  logic        ci_done;
  logic [31:0] ci_result;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_timeout;
  logic        out_ready;
  logic        busy;

  ci_cos_initiator #(.DATA_W(32), .DEPTH(8), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ci_clk_en(ci_clk_en), .ci_reset(ci_reset), .ci_start(ci_start),
    .ci_dataa(ci_dataa), .ci_done(ci_done), .ci_result(ci_result),
    .out_valid(out_valid), .out_data(out_data),
    .out_timeout(out_timeout), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        t;
  } exp_t;

  exp_t expq[$];
  int ncmp = 0;
  int nerr = 0;
  int cyc = 0;
  int nstart = 0;
  int nreset = 0;
  int novc = 0;
  int drops = 0;
  int overlap = 0;
  bit watch = 0;

  logic [31:0] ang [8] = '{32'h3f800000, 32'h00000000, 32'h3fc90fdb,
                           32'h40490fdb, 32'h3f000000, 32'hbf800000,
                           32'h40000000, 32'h3e800000};
  logic [31:0] res [8] = '{32'h3f0a5140, 32'h3f800000, 32'hb33bbd2e,
                           32'hbf800000, 32'h3f60a940, 32'h3f0a5140,
                           32'hbed51133, 32'h3f780a56};

  // behavioural slave: done exactly lat cycles after the start cycle
  int          lat = 6;
  bit          mute = 0;
  bit          sl_busy = 0;
  int          rem = 0;
  logic [31:0] sl_arg;
  logic        sl_done = 1'b0;
  logic [31:0] sl_res = '0;
  logic        man_done = 1'b0;
  logic [31:0] man_res = '0;

  assign ci_done   = sl_done | man_done;
  assign ci_result = man_done ? man_res : sl_res;

  function automatic logic [31:0] cos_lut(input logic [31:0] a);
    logic [31:0] r;
    r = 32'hdeadbeef;
    for (int i = 0; i < 8; i++) if (ang[i] == a) r = res[i];
    return r;
  endfunction

  always @(posedge clk) begin
    if (ci_clk_en) begin
      sl_done <= 1'b0;
      if (ci_reset) begin
        sl_busy = 0;
      end else if (ci_start) begin
        sl_busy = 1;
        sl_arg  = ci_dataa;
        rem     = lat - 1;
        if (rem == 0 && !mute) begin
          sl_done <= 1'b1;
          sl_res  <= cos_lut(sl_arg);
          sl_busy = 0;
        end
      end else if (sl_busy && !mute) begin
        rem--;
        if (rem == 0) begin
          sl_done <= 1'b1;
          sl_res  <= cos_lut(sl_arg);
          sl_busy = 0;
        end
      end
    end
  end

  always @(posedge clk) cyc++;

  // output monitor
  always @(negedge clk) begin
    exp_t e;
    if (!reset && clk_en) begin
      if (out_valid && out_ready) begin
        ncmp++;
        if (expq.size() == 0) begin
          nerr++;
          $display("FAIL unexpected_out got %h/%b required none",
                   out_data, out_timeout);
        end else begin
          e = expq.pop_front();
          if (out_data !== e.d || out_timeout !== e.t) begin
            nerr++;
            $display("FAIL result got %h/%b required %h/%b",
                     out_data, out_timeout, e.d, e.t);
          end
        end
      end
      if (ci_start) begin
        nstart++;
        if (sl_busy) overlap++;
      end
      if (out_valid) novc++;
    end
    if (ci_reset && !reset) nreset++;
    if (watch && !in_ready) drops++;
  end

  task automatic chk(input string nm, input int act, input int req);
    ncmp++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s got %0d required %0d", nm, act, req);
    end
  endtask

  task automatic chkh(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
    ncmp++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s got %h required %h", nm, act, req);
    end
  endtask

  // called just after a posedge; returns just after the accepting edge
  task automatic push(input logic [31:0] a, input logic [31:0] d,
                      input logic t);
    exp_t e;
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_data  = a;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      chk("push_accept", 0, 1);
    end else begin
      e.d = d;
      e.t = t;
      expq.push_back(e);
    end
  endtask

  task automatic wait_start(output int c);
    c = -1000;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ci_start) begin
        c = cyc;
        break;
      end
    end
  endtask

  task automatic wait_ov(output int c);
    c = -1000;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (out_valid) begin
        c = cyc;
        break;
      end
    end
  endtask

  task automatic drain(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      ok = (expq.size() == 0) && !busy;
    end
    chk(nm, int'(ok), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    int st;
    int ov;
    int b;
    int r;
    int frz;
    logic [31:0] snap;

    reset = 1'b1;
    clk_en = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ci_reset_in_reset", int'(ci_reset), 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chkh("rst_out_data", out_data, 32'h0);
    chk("rst_out_timeout", int'(out_timeout), 0);
    chk("rst_ci_start", int'(ci_start), 0);
    chkh("rst_ci_dataa", ci_dataa, 32'h0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_ci_reset", int'(ci_reset), 0);
    @(posedge clk);
    #1;

    // single request latency
    out_ready = 1'b1;
    lat = 6;
    push(32'h3f800000, 32'h3f0a5140, 1'b0);
    c = cyc;
    wait_start(st);
    chk("t1_start_lat", st - c, 1);
    chkh("t1_dataa", ci_dataa, 32'h3f800000);
    wait_ov(ov);
    chk("t1_out_lat", ov - c, 8);
    drain("t1_drain");

    // back-to-back sweep
    b = nstart;
    drops = 0;
    overlap = 0;
    watch = 1;
    for (int i = 0; i < 8; i++) push(ang[i], res[i], 1'b0);
    watch = 0;
    drain("t2_drain");
    chk("t2_starts", nstart - b, 8);
    chk("t2_in_ready_drops", drops, 0);
    chk("t2_overlap", overlap, 0);

    // backpressure in HOLD
    out_ready = 1'b0;
    lat = 3;
    b = nstart;
    push(ang[2], res[2], 1'b0);
    push(ang[3], res[3], 1'b0);
    wait_ov(ov);
    repeat (10) @(posedge clk);
    #1;
    chk("t3_hold_starts", nstart - b, 1);
    chk("t3_hold_valid", int'(out_valid), 1);
    chkh("t3_hold_data", out_data, res[2]);
    out_ready = 1'b1;
    r = cyc;
    wait_start(st);
    chk("t3_restart_lat", st - r, 2);
    drain("t3_drain");

    // timeout
    mute = 1;
    push(ang[4], 32'h7fc00000, 1'b1);
    wait_start(st);
    r = nreset;
    wait_ov(ov);
    chk("t4_timeout_lat", ov - st, 65);
    repeat (4) @(posedge clk);
    #1;
    chk("t4_ci_reset_cycles", nreset - r, 1);
    mute = 0;
    lat = 5;
    push(ang[5], res[5], 1'b0);
    drain("t4_drain");

    // clock-enable freeze mid-WAIT
    lat = 6;
    push(ang[6], res[6], 1'b0);
    wait_start(st);
    repeat (3) @(posedge clk);
    #1;
    snap = ci_dataa;
    clk_en = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h12345678;
    frz = 0;
    repeat (5) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || ci_dataa !== snap || out_valid !== 1'b0 ||
          busy !== 1'b1 || ci_start !== 1'b0 || ci_clk_en !== 1'b0)
        frz++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clk_en = 1'b1;
    chk("t5_frozen", frz, 0);
    wait_ov(ov);
    chk("t5_out_lat", ov - st, 12);
    drain("t5_drain");

    // synchronous reset mid-WAIT with three angles queued
    lat = 20;
    b = nstart;
    for (int i = 0; i < 4; i++) push(ang[i], res[i], 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    expq.delete();
    @(negedge clk);
    chk("t6_busy", int'(busy), 0);
    chk("t6_out_valid", int'(out_valid), 0);
    chk("t6_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    r = novc;
    man_res = 32'h3f0a5140;
    man_done = 1'b1;
    @(posedge clk);
    #1;
    man_done = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("t6_late_done_out", novc - r, 0);
    chk("t6_starts", nstart - b, 1);
    chk("t6_busy_after", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
